cu_seq: RTL and testbench
=========================

# cu_seq

Sequencer for `cu_engine` in the streaming accelerator.
- Holds the 3x3 filter as nine 8-bit weights in a local register file.
- Accepts an upstream stream of 24-bit pixel columns (three rows, one byte each) and drives `data_in` and the 3-step `pe_en_ctrl` ramp.
- Tags each `pe_out` sample that corresponds to a complete 3x3 window and presents it as a valid output.
- Sits between the input DMA/line buffer and the `cu_engine` instance. It processes one row band of `cfg_width` columns per `start`.

## Interface
Parameters:
- `CU_LAT`, 2: cycles from a column on `data_in` to its `pe_out` result (at least 1).
- `W_BITS`, 10: width of the column count.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  weight write strobe.
- `cfg_addr`  in  4  weight index 0..8; values 9..15 are ignored.
- `cfg_wdata`  in  8  weight value.
- `cfg_width`  in  W_BITS  band width in columns; sampled on `start`.
- `start`  in  1  single-cycle pulse that begins a band.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  single-cycle pulse when the band is complete.
- `err`  out  1  sticky; set when `cfg_width` < 3 at `start`; cleared by the next accepted `start`.
- `in_valid`  in  1  upstream column valid.
- `in_ready`  out  1  column accepted when `in_valid` && `in_ready`.
- `in_col`  in  24  pixel column; byte 0 is the top row.
- `filter`  out  72  to `cu_engine`; weight k occupies bits [8k+7:8k].
- `data_in`  out  24  to `cu_engine`.
- `pe_en_ctrl`  out  9  to `cu_engine`.
- `pe_out`  in  16  from `cu_engine`.
- `out_valid`  out  1  result valid; there is no backpressure.
- `out_data`  out  16  result.

## Operation
States: IDLE, PRIME, STREAM, DRAIN, DONE.
- **IDLE**
  - `cfg_we` writes weight `cfg_addr`.
  - `start` latches `cfg_width` and clears `err`.
  - If width ≥ 3, go to PRIME. Otherwise set `err` and go to DONE.
- **PRIME**: hold for 3 cycles so `filter` settles into the engine, then go to STREAM.
- **STREAM**
  - `in_ready` = 1. `data_in` = `in_col` and `pe_en_ctrl` follows the ramp on the accepted beat.
  - Ramp by accepted-column index c: c = 0 gives 9'h007, c = 1 gives 9'h03F, c ≥ 2 gives 9'h1FF.
  - Cycles without a beat: `pe_en_ctrl` = 0 and `data_in` holds its last value.
  - After the accept of column `cfg_width`-1, go to DRAIN.
- **DRAIN**: wait `CU_LAT` cycles, then go to DONE.
- **DONE**: pulse `done` for 1 cycle, then go to IDLE.

Rules:
- `start` while `busy` is ignored.
- `cfg_we` outside IDLE is ignored, so `filter` is constant during a band.
- Results: each accepted column with c ≥ 2 pushes a tag into a `CU_LAT`-deep delay line. When the tag emerges, `out_valid` = 1 and `out_data` = `pe_out` that same cycle.
- A band of width W yields exactly W-2 results.
- The column counter is W_BITS wide. `cfg_width` = 2^W_BITS-1 must complete without wrap.

## Timing
- Reset values:
  - State IDLE; `busy`, `done`, `err`, `in_ready`, `out_valid` = 0.
  - `pe_en_ctrl` = 0, `data_in` = 0.
  - All weights 0, so `filter` = 0.
  - Delay line cleared.
- `busy` rises the cycle after `start` and falls with `done`.
- `data_in`/`pe_en_ctrl` are combinational from `in_col`/the beat in STREAM, so the engine sees a column in its accept cycle.
- Result latency: column accepted at cycle t gives `out_valid` at t+`CU_LAT`.
- Minimum band length (no stalls) is 1 + 3 + W + `CU_LAT` + 1 cycles from `start` to `done`.
- Weight write to `filter` takes 1 cycle.
- Reset mid-band: all outputs return to reset values on the next edge, in-flight tags are dropped, no `done` pulse is issued, and weights are cleared.

## Configuration
- `CU_SEQ_RELU_EN` defined: `out_data` = `pe_out` treated as signed, with negative values replaced by 16'h0000. This adds no latency.
- Undefined: `out_data` = `pe_out` unmodified.

## Structure
- Package `cu_pkg`:
  - state enum;
  - ramp constants PE_EN_1COL = 9'h007, PE_EN_2COL = 9'h03F, PE_EN_FULL = 9'h1FF;
  - NUM_TAPS = 9, TAP_W = 8, COL_W = 24, RES_W = 16.
- One sub-module, `cu_valid_pipe`: a parameterised `CU_LAT`-deep 1-bit delay line with synchronous clear.

## Test plan
- **Identity filter**
  - Stimulus: write weights 0, 4, 8 = 1 and the rest 0; check `filter` = 72'h010000000100000001. Then start with W = 5 and stream columns 0x020100, 0x050403, 0x080706, 0x0B0A09, 0x0E0D0C with no gaps.
  - Required: `pe_en_ctrl` sequence 007, 03F, 1FF, 1FF, 1FF; exactly 3 `out_valid` beats, each `CU_LAT` cycles after columns 2, 3, 4; one `done`.
- **Upstream gaps**: drop `in_valid` for 2 cycles after column 1. Required: `pe_en_ctrl` = 0 during the gap, ramp resumes at 1FF, result count is still W-2.
- **Bad width**: start with W = 2. Required: `err` = 1, `done` pulses 2 cycles after `start`, no `in_ready`, no `out_valid`.
- **Busy guards**: during STREAM, pulse `start` and write weight 0 = 0x7F. Required: both ignored and `filter` unchanged.
- **Reset mid-band**: assert `rst` during column 3. Required: next cycle all outputs are 0 and state is IDLE; a following band with W = 3 produces 1 result.
- **ReLU (`CU_SEQ_RELU_EN`)**: drive `pe_out` = 16'hFFF0 on a valid slot. Required: `out_data` = 0; a 16'h0010 slot passes through unchanged.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared types and constants for the cu_seq sequencer.
//   - cu_state_t : sequencer state encoding
//   - PE_EN_*    : pe_en_ctrl ramp for the first, second and later columns
//   - NUM_TAPS/TAP_W/COL_W/RES_W : filter, column and result geometry
//   - relu16()   : clamps a signed result at zero (used when CU_SEQ_RELU_EN is defined)
package cu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } cu_state_t;

  localparam logic [8:0] PE_EN_1COL = 9'h007;
  localparam logic [8:0] PE_EN_2COL = 9'h03F;
  localparam logic [8:0] PE_EN_FULL = 9'h1FF;

  localparam int NUM_TAPS     = 9;
  localparam int TAP_W        = 8;
  localparam int COL_W        = 24;
  localparam int RES_W        = 16;
  localparam int PRIME_CYCLES = 3;

  // Negative (sign bit set) results become zero, others pass unchanged.
  function automatic logic [RES_W-1:0] relu16(input logic [RES_W-1:0] v);
    logic [RES_W-1:0] r;
    if (v[RES_W-1]) begin
      r = {RES_W{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/cu_valid_pipe.sv
// cu_valid_pipe: DEPTH-deep 1-bit delay line with synchronous clear.
// Ports:
//   clk  in  clock
//   clr  in  synchronous clear of every stage
//   din  in  tag entering the line
//   dout out tag leaving the line DEPTH cycles later
module cu_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stage_r;

  generate
    if (DEPTH == 1) begin : g_single
      // Single-stage delay.
      always_ff @(posedge clk) begin
        if (clr) begin
          stage_r <= 1'b0;
        end else begin
          stage_r <= din;
        end
      end
    end else begin : g_multi
      // Shift the tag one stage per cycle toward the MSB.
      always_ff @(posedge clk) begin
        if (clr) begin
          stage_r <= {DEPTH{1'b0}};
        end else begin
          stage_r <= {stage_r[DEPTH-2:0], din};
        end
      end
    end
  endgenerate

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/cu_seq.sv
// cu_seq: sequencer for cu_engine. Holds the 3x3 filter, streams one band of
// cfg_width pixel columns into the engine with the pe_en_ctrl ramp, and tags
// the pe_out samples that belong to complete 3x3 windows.
// Optional feature macro: CU_SEQ_RELU_EN (clamp negative results to zero).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cfg_we/addr/wdata      weight write (IDLE only, addr 0..8)
//   cfg_width, start       band width and start pulse
//   busy, done, err        band status
//   in_valid/in_ready/in_col  upstream column handshake
//   filter, data_in, pe_en_ctrl, pe_out  cu_engine interface
//   out_valid, out_data    tagged results (no backpressure)
module cu_seq
  import cu_pkg::*;
#(
  parameter int CU_LAT = 2,
  parameter int W_BITS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_addr,
  input  logic [TAP_W-1:0]          cfg_wdata,
  input  logic [W_BITS-1:0]         cfg_width,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [COL_W-1:0]          in_col,
  output logic [NUM_TAPS*TAP_W-1:0] filter,
  output logic [COL_W-1:0]          data_in,
  output logic [8:0]                pe_en_ctrl,
  input  logic [RES_W-1:0]          pe_out,
  output logic                      out_valid,
  output logic [RES_W-1:0]          out_data
);

  cu_state_t          state_r;
  logic [TAP_W-1:0]   weight_r [NUM_TAPS];
  logic [W_BITS-1:0]  width_r;
  logic [W_BITS-1:0]  col_r;
  logic [1:0]         prime_r;
  logic [7:0]         drain_r;
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic               ready_r;
  logic [COL_W-1:0]   hold_r;

  logic               beat_s;
  logic               tag_in_s;
  logic               tag_out_s;
  logic [8:0]         ramp_s;
  logic [RES_W-1:0]   result_s;

  // ready_r is only ever high in STREAM, so a beat implies STREAM.
  assign beat_s = in_valid & ready_r;

  // Ramp selection by accepted-column index and the window-complete tag.
  always_comb begin
    ramp_s   = PE_EN_FULL;
    tag_in_s = 1'b0;
    if (col_r == {W_BITS{1'b0}}) begin
      ramp_s = PE_EN_1COL;
    end else if (col_r == W_BITS'(1'b1)) begin
      ramp_s = PE_EN_2COL;
    end else begin
      ramp_s = PE_EN_FULL;
    end
    // Columns 2 and later close a full 3x3 window.
    if (beat_s && (col_r[W_BITS-1:1] != {(W_BITS-1){1'b0}})) begin
      tag_in_s = 1'b1;
    end else begin
      tag_in_s = 1'b0;
    end
  end

  // Engine drive: the column goes straight through on its accept cycle so
  // the engine sees it without an extra register stage.
  always_comb begin
    data_in    = hold_r;
    pe_en_ctrl = 9'h000;
    if (beat_s) begin
      data_in    = in_col;
      pe_en_ctrl = ramp_s;
    end else begin
      data_in    = hold_r;
      pe_en_ctrl = 9'h000;
    end
  end

  // Flatten the weight register file onto the filter bus.
  always_comb begin
    filter = {(NUM_TAPS*TAP_W){1'b0}};
    for (int k = 0; k < NUM_TAPS; k++) begin
      filter[k*TAP_W +: TAP_W] = weight_r[k];
    end
  end

  // Sequencer FSM, weight file and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      width_r <= {W_BITS{1'b0}};
      col_r   <= {W_BITS{1'b0}};
      prime_r <= 2'd0;
      drain_r <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b0;
      hold_r  <= {COL_W{1'b0}};
      for (int k = 0; k < NUM_TAPS; k++) begin
        weight_r[k] <= {TAP_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      if (beat_s) begin
        hold_r <= in_col;
      end
      case (state_r)
        IDLE: begin
          // Weights may only change between bands.
          if (cfg_we && (cfg_addr < 4'd9)) begin
            weight_r[cfg_addr] <= cfg_wdata;
          end
          if (start) begin
            width_r <= cfg_width;
            col_r   <= {W_BITS{1'b0}};
            prime_r <= 2'd0;
            busy_r  <= 1'b1;
            if (cfg_width < W_BITS'(2'd3)) begin
              err_r   <= 1'b1;
              state_r <= DONE;
            end else begin
              err_r   <= 1'b0;
              state_r <= PRIME;
            end
          end
        end
        PRIME: begin
          if (prime_r == 2'(PRIME_CYCLES - 1)) begin
            ready_r <= 1'b1;
            state_r <= STREAM;
          end else begin
            prime_r <= prime_r + 2'd1;
          end
        end
        STREAM: begin
          if (beat_s) begin
            // Counter never needs to exceed width-1, so the full range completes.
            col_r <= col_r + W_BITS'(1'b1);
            if (col_r == (width_r - W_BITS'(1'b1))) begin
              ready_r <= 1'b0;
              drain_r <= 8'd0;
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last tag leaves the delay line in the final DRAIN cycle.
          if (drain_r == 8'(CU_LAT - 1)) begin
            state_r <= DONE;
          end else begin
            drain_r <= drain_r + 8'd1;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  cu_valid_pipe #(
    .DEPTH (CU_LAT)
  ) u_valid_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in_s),
    .dout (tag_out_s)
  );

  // Result path: same-cycle pass of pe_out, optionally clamped at zero.
  always_comb begin
`ifdef CU_SEQ_RELU_EN
    result_s = relu16(pe_out);
`else
    result_s = pe_out;
`endif
    if (tag_out_s) begin
      out_data = result_s;
    end else begin
      out_data = {RES_W{1'b0}};
    end
  end

  assign out_valid = tag_out_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign in_ready  = ready_r;

endmodule

// File: tb/tb_cu_seq.sv
// tb_cu_seq: self-checking bench for cu_seq. Weight writes and bands are
// driven from stimulus tables; expected result cycles go into a scoreboard
// queue on each accepted column and are popped when out_valid appears.
module tb_cu_seq;

  localparam int CU_LAT = 2;
  localparam int W_BITS = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [3:0]        cfg_addr;
  logic [7:0]        cfg_wdata;
  logic [W_BITS-1:0] cfg_width;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              in_valid;
  logic              in_ready;
  logic [23:0]       in_col;
  logic [71:0]       filter;
  logic [23:0]       data_in;
  logic [8:0]        pe_en_ctrl;
  logic [15:0]       pe_out;
  logic              out_valid;
  logic [15:0]       out_data;

  cu_seq #(.CU_LAT(CU_LAT), .W_BITS(W_BITS)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_width(cfg_width), .start(start),
    .busy(busy), .done(done), .err(err), .in_valid(in_valid),
    .in_ready(in_ready), .in_col(in_col), .filter(filter),
    .data_in(data_in), .pe_en_ctrl(pe_en_ctrl), .pe_out(pe_out),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [71:0] exp_filter;
  } wvec_t;

  typedef struct {
    int w;
    int gap_at;
    int gap_len;
    bit guard;
    int rst_col;
    bit relu_pat;
  } band_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          exp_q[$];
  logic [23:0] last_data;
  logic [71:0] exp_filter;
  bit          pat_relu;
  wvec_t       wtab[7];
  band_t       btab[10];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine stand-in: a known value every cycle.
  function automatic logic [15:0] pe_val(input int c, input bit relu_pat);
    logic [31:0] cv;
    cv = c;
    if (relu_pat) return cv[0] ? 16'hFFF0 : 16'h0010;
    else return {4'h3, cv[11:0]};
  endfunction

  function automatic logic [15:0] exp_out(input logic [15:0] v);
`ifdef CU_SEQ_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [8:0] exp_ramp(input int c);
    if (c == 0) return 9'h007;
    else if (c == 1) return 9'h03F;
    else return 9'h1FF;
  endfunction

  function automatic logic [23:0] col_val(input int k);
    return {8'(3 * k + 2), 8'(3 * k + 1), 8'(3 * k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pe_out = pe_val(cyc, pat_relu);
  endtask

  task automatic run_band(input band_t b);
    int start_cyc, sent, gap_left, last_acc, results, done_cyc, e;
    bit done_seen;
    pat_relu  = b.relu_pat;
    cfg_width = W_BITS'(b.w);
    start     = 1'b1;
    in_valid  = 1'b0;
    #1;
    chk("busy_before_start", 72'(busy), 72'(0));
    start_cyc = cyc;
    tick();
    sent = 0; gap_left = 0; last_acc = 0; results = 0; done_cyc = 0; done_seen = 1'b0;
    for (int i = 0; i < b.w + 60 && !done_seen; i++) begin
      start    = 1'b0;
      cfg_we   = 1'b0;
      in_valid = (sent < b.w) && (gap_left == 0);
      in_col   = col_val(sent);
      if (b.guard && sent == 2) begin
        start = 1'b1; cfg_width = W_BITS'(3);
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'h7F;
      end
      #1;
      if (in_valid && in_ready) begin
        chk("pe_en_ramp", 72'(pe_en_ctrl), 72'(exp_ramp(sent)));
        chk("data_in_beat", 72'(data_in), 72'(in_col));
        if (sent == 0) chk("first_beat_cycle", 72'(cyc - start_cyc), 72'(4));
        if (sent >= 2) exp_q.push_back(cyc + CU_LAT);
        last_data = in_col;
        last_acc  = cyc;
        if (sent == b.gap_at) gap_left = b.gap_len;
        if (sent == b.rst_col) rst = 1'b1;
        sent++;
      end else begin
        chk("pe_en_no_beat", 72'(pe_en_ctrl), 72'(0));
        chk("data_in_hold", 72'(data_in), 72'(last_data));
        if (gap_left > 0) gap_left--;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 72'(1), 72'(0));
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 72'(cyc), 72'(e));
          chk("out_data", 72'(out_data), 72'(exp_out(pe_val(cyc, pat_relu))));
          results++;
        end
      end
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        chk("busy_at_done", 72'(busy), 72'(0));
      end else begin
        chk("busy_in_band", 72'(busy), 72'(1));
      end
      if (rst) break;
      if (!done_seen) tick();
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    if (b.rst_col >= 0) begin
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_busy", 72'(busy), 72'(0));
      chk("rst_done", 72'(done), 72'(0));
      chk("rst_err", 72'(err), 72'(0));
      chk("rst_in_ready", 72'(in_ready), 72'(0));
      chk("rst_out_valid", 72'(out_valid), 72'(0));
      chk("rst_out_data", 72'(out_data), 72'(0));
      chk("rst_pe_en", 72'(pe_en_ctrl), 72'(0));
      chk("rst_data_in", 72'(data_in), 72'(0));
      chk("rst_filter", filter, 72'(0));
      exp_q.delete();
      last_data  = 24'h0;
      exp_filter = 72'h0;
      tick();
      chk("rst_no_out_valid", 72'(out_valid), 72'(0));
      chk("rst_no_done", 72'(done), 72'(0));
      return;
    end
    if (!done_seen) chk("done_timeout", 72'(0), 72'(1));
    in_valid = 1'b0;
    chk("result_count", 72'(results), 72'((b.w < 3) ? 0 : b.w - 2));
    chk("accepted_cols", 72'(sent), 72'((b.w < 3) ? 0 : b.w));
    chk("err_flag", 72'(err), 72'(b.w < 3));
    if (b.w < 3) begin
      chk("bad_width_done_cycle", 72'(done_cyc - start_cyc), 72'(2));
    end else begin
      chk("done_after_last", 72'(done_cyc - last_acc), 72'(CU_LAT + 2));
      if (b.gap_len == 0) chk("band_length", 72'(done_cyc - start_cyc), 72'(5 + b.w + CU_LAT));
    end
    chk("scoreboard_empty", 72'(exp_q.size()), 72'(0));
    chk("filter_in_band", filter, exp_filter);
    tick();
    chk("done_single_pulse", 72'(done), 72'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wtab[0] = '{4'd0,  8'h01, 72'h000000000000000001};
    wtab[1] = '{4'd2,  8'h55, 72'h000000000000550001};
    wtab[2] = '{4'd4,  8'h01, 72'h000000000100550001};
    wtab[3] = '{4'd8,  8'h01, 72'h010000000100550001};
    wtab[4] = '{4'd9,  8'hFF, 72'h010000000100550001};
    wtab[5] = '{4'd2,  8'h00, 72'h010000000100000001};
    wtab[6] = '{4'd15, 8'hAA, 72'h010000000100000001};

    //            w    gap_at gap_len guard rst_col relu
    btab[0] = '{5,    -1, 0, 1'b0, -1, 1'b0};   // identity band
    btab[1] = '{5,     1, 2, 1'b0, -1, 1'b0};   // upstream gap after column 1
    btab[2] = '{2,    -1, 0, 1'b0, -1, 1'b0};   // bad width
    btab[3] = '{6,    -1, 0, 1'b1, -1, 1'b0};   // start/cfg_we during STREAM
    btab[4] = '{3,    -1, 0, 1'b0, -1, 1'b0};   // minimum width
    btab[5] = '{6,    -1, 0, 1'b0,  3, 1'b0};   // reset during column 3
    btab[6] = '{3,    -1, 0, 1'b0, -1, 1'b0};   // band after reset
    btab[7] = '{8,    -1, 0, 1'b0, -1, 1'b1};   // negative / positive results
    btab[8] = '{1,    -1, 0, 1'b0, -1, 1'b0};   // bad width 1
    btab[9] = '{1023, -1, 0, 1'b0, -1, 1'b0};   // full counter range

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 8'h00;
    cfg_width = '0; start = 1'b0; in_valid = 1'b0; in_col = 24'h0;
    pe_out = 16'h0; pat_relu = 1'b0; last_data = 24'h0; exp_filter = 72'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", 72'(busy), 72'(0));
    chk("reset_done", 72'(done), 72'(0));
    chk("reset_err", 72'(err), 72'(0));
    chk("reset_in_ready", 72'(in_ready), 72'(0));
    chk("reset_out_valid", 72'(out_valid), 72'(0));
    chk("reset_pe_en", 72'(pe_en_ctrl), 72'(0));
    chk("reset_data_in", 72'(data_in), 72'(0));
    chk("reset_filter", filter, 72'(0));

    for (int i = 0; i < 7; i++) begin
      cfg_we = 1'b1; cfg_addr = wtab[i].addr; cfg_wdata = wtab[i].data;
      tick();
      cfg_we = 1'b0;
      #1;
      exp_filter = wtab[i].exp_filter;
      chk("filter_write", filter, exp_filter);
    end

    for (int i = 0; i < 10; i++) begin
      run_band(btab[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
